// File: rtl/param_pkg.sv
// Shared loader types plus the reset/enable flop macros.
// Optional checksum support is enabled with RVC_LOADER_CSUM_EN.
`ifndef RVC_RST_MSFF
`define RVC_RST_MSFF(q, d, clk, rstN, rv) \
  always_ff @(posedge clk or negedge rstN) \
    if (!rstN) q <= (rv); \
    else q <= (d);
`endif

`ifndef RVC_EN_MSFF
`define RVC_EN_MSFF(q, d, en, clk, rstN, rv) \
  always_ff @(posedge clk or negedge rstN) \
    if (!rstN) q <= (rv); \
    else if (en) q <= (d);
`endif

package param_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } t_loader_state;

  function automatic logic isLoading(
    input t_loader_state s
  );
    return (s == LEN) || (s == DATA) ||
           (s == CSUM);
  endfunction

endpackage

// File: rtl/rvc_imem_loader_packer.sv
// Little-endian byte-to-word packer shared by
// the length, payload and checksum fields.
module rvc_byte_packer
  import param_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Clear,
  input  logic        ByteEn,
  input  logic [7:0]  RxByte,
  output logic        WordValid,
  output logic [31:0] Word
);

  logic [1:0]  byteCnt;
  logic [1:0]  byteCntNext;
  logic [23:0] shiftReg;

  always_comb begin
    byteCntNext = byteCnt;
    if (Clear)
      byteCntNext = 2'd0;
    else if (ByteEn)
      byteCntNext = byteCnt + 2'd1;
  end

  `RVC_RST_MSFF(byteCnt, byteCntNext, Clk, Rst, 2'd0)

  // Newest byte enters at the top so byte 0 ends up in [7:0].
  `RVC_EN_MSFF(shiftReg, Word[31:8], ByteEn, Clk, Rst, 24'd0)

  assign Word      = {RxByte, shiftReg};
  assign WordValid = ByteEn && (byteCnt == 2'd3);

endmodule

// File: rtl/rvc_imem_loader.sv
// Boot loader: byte stream -> I_MEM words, core held in reset.
// Define RVC_LOADER_CSUM_EN to require a trailing checksum.
module rvc_imem_loader
  import param_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        LoadStart,
  input  logic        RxValid,
  input  logic [7:0]  RxByte,
  output logic        RxReady,
  output logic        ImemWrEn,
  output logic [31:0] ImemWrAddr,
  output logic [31:0] ImemWrData,
  output logic        CoreRst,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam int IW = $clog2(MEM_WORDS) + 1;
  localparam logic [31:0] MAX_WORDS = 32'(MEM_WORDS);

  t_loader_state state;
  logic [IW-1:0] wordIdx;
  logic [IW-1:0] wordCnt;
  logic          byteEn;
  logic          startAcc;
  logic          wordValid;
  logic [31:0]   word;
  logic          lastWord;
`ifdef RVC_LOADER_CSUM_EN
  logic [31:0]   sum;
`endif

  assign RxReady  = isLoading(state);
  assign Busy     = isLoading(state);
  assign byteEn   = RxValid && RxReady;
  assign startAcc = LoadStart && !Busy;
  assign lastWord = wordIdx == (wordCnt - IW'(1));

  rvc_byte_packer u_packer (
    .Clk       (Clk),
    .Rst       (Rst),
    .Clear     (startAcc),
    .ByteEn    (byteEn),
    .RxByte    (RxByte),
    .WordValid (wordValid),
    .Word      (word)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      ImemWrEn   <= 1'b0;
      ImemWrAddr <= 32'h0;
      ImemWrData <= 32'h0;
      CoreRst    <= 1'b1;
      Done       <= 1'b0;
      Error      <= 1'b0;
      wordIdx    <= '0;
      wordCnt    <= '0;
`ifdef RVC_LOADER_CSUM_EN
      sum        <= 32'h0;
`endif
    end else begin
      ImemWrEn <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (LoadStart) begin
            state   <= LEN;
            Done    <= 1'b0;
            Error   <= 1'b0;
            CoreRst <= 1'b1;
            wordIdx <= '0;
`ifdef RVC_LOADER_CSUM_EN
            sum     <= 32'h0;
`endif
          end else if (state == DONE) begin
            // One cycle in DONE lets the last write retire first.
            Done    <= 1'b1;
            CoreRst <= 1'b0;
          end
        end
        LEN: begin
          if (wordValid) begin
            if (word == 32'h0 || word > MAX_WORDS) begin
              state <= ERR;
              Error <= 1'b1;
            end else begin
              wordCnt <= word[IW-1:0];
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (wordValid) begin
            ImemWrEn   <= 1'b1;
            ImemWrAddr <= BASE_ADDR + (32'(wordIdx) << 2);
            ImemWrData <= word;
            wordIdx    <= wordIdx + IW'(1);
`ifdef RVC_LOADER_CSUM_EN
            sum        <= sum + word;
            if (lastWord)
              state <= CSUM;
`else
            if (lastWord)
              state <= DONE;
`endif
          end
        end
`ifdef RVC_LOADER_CSUM_EN
        CSUM: begin
          if (wordValid) begin
            if (word == sum) begin
              state <= DONE;
            end else begin
              state <= ERR;
              Error <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_imem_loader.sv
// Randomized bench for rvc_imem_loader with a byte-count model.
// Honours RVC_LOADER_CSUM_EN the same way as the design.
module tb_rvc_imem_loader;

  localparam int          MW = 1024;
  localparam logic [31:0] BA = 32'h0;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        LoadStart = 1'b0;
  logic        RxValid = 1'b0;
  logic [7:0]  RxByte = 8'h0;
  logic        RxReady;
  logic        ImemWrEn;
  logic [31:0] ImemWrAddr;
  logic [31:0] ImemWrData;
  logic        CoreRst;
  logic        Busy;
  logic        Done;
  logic        Error;

  rvc_imem_loader #(
    .MEM_WORDS (MW),
    .BASE_ADDR (BA)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .LoadStart  (LoadStart),
    .RxValid    (RxValid),
    .RxByte     (RxByte),
    .RxReady    (RxReady),
    .ImemWrEn   (ImemWrEn),
    .ImemWrAddr (ImemWrAddr),
    .ImemWrData (ImemWrData),
    .CoreRst    (CoreRst),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  bit go = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: expectations follow from how many bytes were taken.
  logic [7:0]  q[$];
  bit          mLoad = 0;
  bit          mWrEn = 0;
  logic [31:0] mAddr = 0;
  logic [31:0] mData = 0;
  bit          mDone = 0;
  bit          mErr = 0;
  bit          mCoreRst = 1;
  bit          pend = 0;
  logic [31:0] nW = 0;
  logic [31:0] mSum = 0;

  function automatic logic [31:0] qw(input int i);
    return {q[i+3], q[i+2], q[i+1], q[i]};
  endfunction

  task automatic takeByte(input logic [7:0] b);
    int n;
    q.push_back(b);
    n = q.size();
    if (n == 4) begin
      nW = qw(0);
      if (nW == 0 || nW > MW) begin
        mErr  = 1;
        mLoad = 0;
      end
    end else if (n % 4 == 0) begin
      if (n <= 4 + 4 * int'(nW)) begin
        mWrEn = 1;
        mAddr = BA + 32'((n - 8) / 4) * 32'd4;
        mData = qw(n - 4);
        mSum  = mSum + mData;
`ifndef RVC_LOADER_CSUM_EN
        if (n == 4 + 4 * int'(nW)) begin
          pend  = 1;
          mLoad = 0;
        end
`endif
      end else begin
        if (qw(n - 4) == mSum) pend = 1;
        else mErr = 1;
        mLoad = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge Clk or negedge Rst);
    if (!Rst) begin
      q.delete();
      mLoad = 0; mWrEn = 0; mAddr = 0; mData = 0;
      mDone = 0; mErr = 0; mCoreRst = 1; pend = 0;
    end else begin
      mWrEn = 0;
      if (pend) begin
        mDone = 1; mCoreRst = 0; pend = 0;
      end
      if (!mLoad && LoadStart) begin
        q.delete();
        mLoad = 1; mDone = 0; mErr = 0;
        mCoreRst = 1; pend = 0; mSum = 0;
      end else if (mLoad && RxValid) begin
        takeByte(RxByte);
      end
    end
  end

  logic [31:0] wrA[$];
  logic [31:0] wrD[$];

  initial forever begin
    @(negedge Clk);
    if (go) begin
      chk("RxReady", 32'(RxReady), 32'(mLoad));
      chk("Busy", 32'(Busy), 32'(mLoad));
      chk("ImemWrEn", 32'(ImemWrEn), 32'(mWrEn));
      chk("ImemWrAddr", ImemWrAddr, mAddr);
      chk("ImemWrData", ImemWrData, mData);
      chk("Done", 32'(Done), 32'(mDone));
      chk("Error", 32'(Error), 32'(mErr));
      chk("CoreRst", 32'(CoreRst), 32'(mCoreRst));
      if (ImemWrEn === 1'b1) begin
        wrA.push_back(ImemWrAddr);
        wrD.push_back(ImemWrData);
      end
    end
  end

  logic [7:0] img[$];

  task automatic pushW(input logic [31:0] w);
    for (int i = 0; i < 4; i++)
      img.push_back(w[8*i +: 8]);
  endtask

  task automatic basicImg(input logic [31:0] cs);
    img.delete();
    pushW(32'd2);
    pushW(32'h13);
    pushW(32'h6F);
`ifdef RVC_LOADER_CSUM_EN
    pushW(cs);
`else
    if (cs == 32'hFFFF_FFFF) pushW(cs);
`endif
  endtask

  task automatic randImg(input int n, input bit bad);
    logic [31:0] s;
    logic [31:0] w;
    s = 0;
    img.delete();
    pushW(32'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      s = s + w;
      pushW(w);
    end
`ifdef RVC_LOADER_CSUM_EN
    pushW(bad ? s + 32'd1 : s);
`else
    if (bad && n < 0) pushW(s);
`endif
  endtask

  task automatic sendBytes(
    input int from,
    input int to,
    input int gap
  );
    for (int i = from; i < to; i++) begin
      @(posedge Clk); #2;
      RxValid = 1'b1;
      RxByte  = img[i];
      if (gap > 0 && i != to - 1) begin
        @(posedge Clk); #2;
        RxValid = 1'b0;
        RxByte  = 8'($urandom);
        repeat (gap - 1) @(posedge Clk);
      end
    end
    @(posedge Clk); #2;
    RxValid = 1'b0;
    RxByte  = 8'($urandom);
  endtask

  task automatic pulseStart();
    @(posedge Clk); #2;
    LoadStart = 1'b1;
    @(posedge Clk); #2;
    LoadStart = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge Clk);
    #1;
  endtask

  task automatic chkBasicWrites();
    chk("nWrites", 32'(wrA.size()), 32'd2);
    if (wrA.size() == 2) begin
      chk("wr0Addr", wrA[0], 32'h0);
      chk("wr0Data", wrD[0], 32'h13);
      chk("wr1Addr", wrA[1], 32'h4);
      chk("wr1Data", wrD[1], 32'h6F);
    end
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #2 go = 1;
    idle(1);
    chk("rstRxReady", 32'(RxReady), 32'd0);
    chk("rstCoreRst", 32'(CoreRst), 32'd1);
    chk("rstWrAddr", ImemWrAddr, 32'd0);
    Rst = 1'b1;

    // Basic load with Done timing pinned.
    basicImg(32'h82);
    wrA.delete(); wrD.delete();
    pulseStart();
    chk("firstReady", 32'(RxReady), 32'd1);
    sendBytes(0, img.size(), 0);
    idle(1);
    chk("lastWrEn", 32'(ImemWrEn), 32'd1);
    chk("doneEarly", 32'(Done), 32'd0);
    idle(1);
    chk("doneT2", 32'(Done), 32'd1);
    chk("coreRstT2", 32'(CoreRst), 32'd0);
    chkBasicWrites();

    // Gapped stream.
    wrA.delete(); wrD.delete();
    pulseStart();
    sendBytes(0, img.size(), 3);
    idle(3);
    chk("gapDone", 32'(Done), 32'd1);
    chkBasicWrites();

    // Zero length.
    img.delete(); pushW(32'd0);
    wrA.delete();
    pulseStart();
    sendBytes(0, 4, 0);
    idle(2);
    chk("n0Error", 32'(Error), 32'd1);
    chk("n0CoreRst", 32'(CoreRst), 32'd1);
    chk("n0Writes", 32'(wrA.size()), 32'd0);

    // Oversize length.
    img.delete(); pushW(32'(MW + 1));
    pulseStart();
    sendBytes(0, 4, 1);
    idle(2);
    chk("bigError", 32'(Error), 32'd1);
    chk("bigWrites", 32'(wrA.size()), 32'd0);

    // Full-capacity image.
    randImg(MW, 0);
    pulseStart();
    sendBytes(0, img.size(), 0);
    idle(3);
    chk("fullDone", 32'(Done), 32'd1);
    chk("fullWrites", 32'(wrA.size()), 32'(MW));
    if (wrA.size() > 0)
      chk("fullLastAddr", wrA[$], BA + 32'(4 * (MW - 1)));

`ifdef RVC_LOADER_CSUM_EN
    basicImg(32'h83);
    pulseStart();
    sendBytes(0, img.size(), 0);
    idle(3);
    chk("csumError", 32'(Error), 32'd1);
    chk("csumCoreRst", 32'(CoreRst), 32'd1);
`endif

    // Reset during the second payload word.
    basicImg(32'h82);
    pulseStart();
    sendBytes(0, 10, 0);
    Rst = 1'b0;
    idle(1);
    chk("midRxReady", 32'(RxReady), 32'd0);
    chk("midWrData", ImemWrData, 32'd0);
    chk("midCoreRst", 32'(CoreRst), 32'd1);
    @(posedge Clk); #2 Rst = 1'b1;
    wrA.delete(); wrD.delete();
    pulseStart();
    sendBytes(0, img.size(), 0);
    idle(3);
    chk("afterRstDone", 32'(Done), 32'd1);
    chkBasicWrites();

    // LoadStart in DATA is ignored; from DONE it restarts.
    wrA.delete(); wrD.delete();
    pulseStart();
    sendBytes(0, 9, 0);
    pulseStart();
    sendBytes(9, img.size(), 0);
    idle(3);
    chk("ignDone", 32'(Done), 32'd1);
    chkBasicWrites();
    pulseStart();
    idle(1);
    chk("restartDone", 32'(Done), 32'd0);
    chk("restartCoreRst", 32'(CoreRst), 32'd1);
    sendBytes(0, img.size(), 0);
    idle(3);

    // Random images, gaps and checksum corruption.
    for (int t = 0; t < 24; t++) begin
      randImg(int'($urandom_range(1, 8)),
              $urandom_range(0, 3) == 0);
      pulseStart();
      sendBytes(0, img.size(), int'($urandom_range(0, 3)));
      idle(int'($urandom_range(2, 5)));
    end

    go = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
